memory_arbiter_rr: RTL and testbench

- Parametrised successor to the single-core memory controller: arbitrates CPUS cores' instruction and data requests onto one variable-latency RAM port.
- Registered, stateful grant replaces combinational muxing: data requests beat instruction requests, fair round-robin within each class, grant held until the RAM reports ACCESS.
- Sits between the per-core caches and the RAM model, in place of the single-core controller.

---
 rtl/memory_arbiter_rr.sv | 168 ++++++++++++++++
 tb/tb_memory_arbiter_rr.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter that puts CPUS cores' instruction and data requests onto one RAM port.
// Data requests beat instruction requests, and the grant is held until the RAM reports ACCESS.
module memory_arbiter_rr #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*AW-1:0]   iaddr,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*DW-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*DW-1:0]   iload,
    output logic [CPUS*DW-1:0]   dload,
    input  logic [1:0]           ramstate,
    input  logic [DW-1:0]        ramload,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    output logic                 ramREN,
    output logic                 ramWEN
);

    localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RamAccess = 2'b10;
    localparam logic [1:0] RamError  = 2'b11;

    typedef enum logic [1:0] {StIdle, StXfer, StRetry} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          owner_data_q, owner_data_d;
    logic [IW-1:0] dptr_q, dptr_d, iptr_q, iptr_d;

    logic [CPUS-1:0] dreq;
    logic [AW-1:0]   own_daddr, own_iaddr;
    logic [DW-1:0]   own_dstore;
    logic            own_dren, own_dwen, own_iren;

    assign dreq       = dREN | dWEN;
    assign own_daddr  = daddr[owner_q*AW +: AW];
    assign own_iaddr  = iaddr[owner_q*AW +: AW];
    assign own_dstore = dstore[owner_q*DW +: DW];
    assign own_dren   = dREN[owner_q];
    assign own_dwen   = dWEN[owner_q];
    assign own_iren   = iREN[owner_q];

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] c);
        return (c == IW'(CPUS - 1)) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        logic          found;
        logic          rd;
        logic [IW-1:0] cand;
        state_d      = state_q;
        owner_d      = owner_q;
        owner_data_d = owner_data_q;
        dptr_d       = dptr_q;
        iptr_d       = iptr_q;
        iwait        = '1;
        dwait        = '1;
        iload        = '0;
        dload        = '0;
        ramaddr      = '0;
        ramstore     = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        found        = 1'b0;
        rd           = 1'b0;
        cand         = '0;

        unique case (state_q)
            StIdle: begin
                // Cyclic scan from the class pointer; data class scanned first.
                if (|dreq) begin
                    cand = dptr_q;
                    for (int k = 0; k < int'(CPUS); k++) begin
                        if (!found && dreq[cand]) begin
                            found   = 1'b1;
                            owner_d = cand;
                        end
                        cand = next_idx(cand);
                    end
                    owner_data_d = 1'b1;
                end else if (|iREN) begin
                    cand = iptr_q;
                    for (int k = 0; k < int'(CPUS); k++) begin
                        if (!found && iREN[cand]) begin
                            found   = 1'b1;
                            owner_d = cand;
                        end
                        cand = next_idx(cand);
                    end
                    owner_data_d = 1'b0;
                end
                if (found) state_d = StXfer;
            end
            StXfer: begin
                if (owner_data_q) begin
                    ramaddr  = own_daddr;
                    ramstore = own_dstore;
                    ramWEN   = own_dwen;
                    rd       = own_dren & ~own_dwen;
                end else begin
                    ramaddr  = own_iaddr;
                    rd       = 1'b1;
                end
                ramREN = rd;
                if (owner_data_q ? !(own_dren | own_dwen) : !own_iren) begin
                    state_d = StIdle;
                end else if (ramstate == RamAccess) begin
                    state_d = StIdle;
                    if (owner_data_q) begin
                        dwait[owner_q] = 1'b0;
                        if (rd) dload[owner_q*DW +: DW] = ramload;
                        dptr_d = next_idx(owner_q);
                    end else begin
                        iwait[owner_q] = 1'b0;
                        iload[owner_q*DW +: DW] = ramload;
                        iptr_d = next_idx(owner_q);
                    end
                end else if (ramstate == RamError) begin
                    state_d = StRetry;
                end
            end
            StRetry: begin
                ramaddr  = owner_data_q ? own_daddr : own_iaddr;
                ramstore = owner_data_q ? own_dstore : '0;
                state_d  = StXfer;
            end
            default: state_d = StIdle;
        endcase

        // A transfer caught by reset must never signal completion.
        if (RST) begin
            iwait    = '1;
            dwait    = '1;
            iload    = '0;
            dload    = '0;
            ramaddr  = '0;
            ramstore = '0;
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            owner_data_q <= 1'b0;
            dptr_q       <= '0;
            iptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_data_q <= owner_data_d;
            dptr_q       <= dptr_d;
            iptr_q       <= iptr_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Randomised bench for memory_arbiter_rr: well-behaved requesters, a random RAM and random
// resets, with every output compared each cycle against a transaction-level model.
module tb_memory_arbiter_rr;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NCYC = 4000;

    logic                CLK = 1'b0;
    logic                RST;
    logic [CPUS-1:0]     iREN, dREN, dWEN;
    logic [CPUS*AW-1:0]  iaddr, daddr;
    logic [CPUS*DW-1:0]  dstore;
    logic [CPUS-1:0]     iwait, dwait;
    logic [CPUS*DW-1:0]  iload, dload;
    logic [1:0]          ramstate;
    logic [DW-1:0]       ramload;
    logic [AW-1:0]       ramaddr;
    logic [DW-1:0]       ramstore;
    logic                ramREN, ramWEN;

    memory_arbiter_rr #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload), .ramstate(ramstate), .ramload(ramload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // Requester side: one outstanding request per core and class, held until served.
    bit          dpend [CPUS];
    bit [1:0]    dkind [CPUS];   // bit0 read, bit1 write
    logic [31:0] dadr  [CPUS];
    logic [31:0] dst   [CPUS];
    bit          ipend [CPUS];
    logic [31:0] iadr  [CPUS];

    // Model: the granted transaction (if any) and the next-in-line core per class.
    bit m_busy, m_retry, m_data;
    int m_core;
    int m_ptr [2];   // [1] data, [0] instruction

    logic [CPUS-1:0]    e_iwait, e_dwait;
    logic [CPUS*DW-1:0] e_iload, e_dload;
    logic [AW-1:0]      e_addr;
    logic [DW-1:0]      e_store;
    logic               e_ren, e_wen;

    initial begin
        bit rd, wr, live, found;
        int r, c;
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
        ramstate = 2'b00; ramload = '0;
        m_busy = 0; m_retry = 0; m_data = 0; m_core = 0; m_ptr[0] = 0; m_ptr[1] = 0;
        for (int i = 0; i < CPUS; i++) begin
            dpend[i] = 0; dkind[i] = 0; dadr[i] = 0; dst[i] = 0;
            ipend[i] = 1; iadr[i] = 32'h100 + 32'(i) * 32'h40;
        end
        @(posedge CLK); #1;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            RST = (cyc < 2) || ($urandom_range(0, 99) == 0);
            for (int i = 0; i < CPUS; i++) begin
                if (cyc >= 4 && !dpend[i] && $urandom_range(0, 2) == 0) begin
                    dpend[i] = 1; dkind[i] = 2'($urandom_range(1, 3));
                    dadr[i] = $urandom; dst[i] = $urandom;
                end
                if (cyc >= 4 && !ipend[i] && $urandom_range(0, 2) == 0) begin
                    ipend[i] = 1; iadr[i] = $urandom;
                end
                dREN[i] = dpend[i] & dkind[i][0];
                dWEN[i] = dpend[i] & dkind[i][1];
                iREN[i] = ipend[i];
                daddr[i*AW +: AW] = dadr[i];
                dstore[i*DW +: DW] = dst[i];
                iaddr[i*AW +: AW] = iadr[i];
            end
            r = $urandom_range(0, 9);
            ramstate = (r < 3) ? 2'b01 : (r == 3) ? 2'b00 : (r < 8) ? 2'b10 : 2'b11;
            ramload = $urandom;

            e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
            e_addr = '0; e_store = '0; e_ren = 0; e_wen = 0;
            if (!RST && m_busy) begin
                c = m_core;
                wr = m_data && dWEN[c];
                rd = m_data ? (dREN[c] && !dWEN[c]) : 1'b1;
                live = m_data ? (dREN[c] || dWEN[c]) : iREN[c];
                e_addr = m_data ? dadr[c] : iadr[c];
                e_store = m_data ? dst[c] : '0;
                if (!m_retry) begin
                    e_ren = rd; e_wen = wr;
                    if (live && ramstate == 2'b10) begin
                        if (m_data) begin
                            e_dwait[c] = 1'b0;
                            if (rd) e_dload[c*DW +: DW] = ramload;
                        end else begin
                            e_iwait[c] = 1'b0;
                            e_iload[c*DW +: DW] = ramload;
                        end
                    end
                end
            end

            #3;
            check("iwait", 128'(iwait), 128'(e_iwait));
            check("dwait", 128'(dwait), 128'(e_dwait));
            check("iload", 128'(iload), 128'(e_iload));
            check("dload", 128'(dload), 128'(e_dload));
            check("ramaddr", 128'(ramaddr), 128'(e_addr));
            check("ramstore", 128'(ramstore), 128'(e_store));
            check("ramREN", 128'(ramREN), 128'(e_ren));
            check("ramWEN", 128'(ramWEN), 128'(e_wen));

            // Advance the model across the coming edge.
            if (RST) begin
                m_busy = 0; m_retry = 0; m_ptr[0] = 0; m_ptr[1] = 0;
            end else if (!m_busy) begin
                found = 0;
                for (int k = 0; k < CPUS; k++) begin
                    c = (m_ptr[1] + k) % CPUS;
                    if (!found && (dREN[c] || dWEN[c])) begin
                        found = 1; m_core = c; m_data = 1;
                    end
                end
                for (int k = 0; k < CPUS; k++) begin
                    c = (m_ptr[0] + k) % CPUS;
                    if (!found && iREN[c]) begin
                        found = 1; m_core = c; m_data = 0;
                    end
                end
                m_busy = found;
            end else if (m_retry) begin
                m_retry = 0;
            end else begin
                c = m_core;
                live = m_data ? (dREN[c] || dWEN[c]) : iREN[c];
                if (!live) m_busy = 0;
                else if (ramstate == 2'b10) begin
                    m_busy = 0;
                    m_ptr[m_data ? 1 : 0] = (c + 1) % CPUS;
                end else if (ramstate == 2'b11) m_retry = 1;
            end
            for (int i = 0; i < CPUS; i++) begin
                if (!e_dwait[i]) dpend[i] = 0;
                if (!e_iwait[i]) ipend[i] = 0;
            end
            @(posedge CLK); #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
